sprite_pixel_pipe: RTL and testbench
====================================

// Module: sprite_pixel_pipe
// PURPOSE
//  Downstream of the idle/menu display tile decoder: consumes its per-pixel tile flags and
//  50x50 sprite address, fetches the glyph pixel from synchronous sprite ROM, applies
//  colour selection (normal/welcome/highlight with blink) and drives registered VGA RGB+sync.
//  Delays hsync/vsync/active so they stay aligned with the pixel colour.
// PARAMETERS
//  ROM_DEPTH      300000   valid sprite ROM words; addresses >= ROM_DEPTH read as transparent
//  BLINK_FRAMES   30       frames per blink half-period (highlight on/off)
//  FG_COLOR       12'hFFF  normal glyph colour {r,g,b}
//  WEL_COLOR      12'h0F0  welcome-text glyph colour
//  HL_COLOR       12'hFF0  highlighted glyph colour
//  BG_COLOR       12'h000  colour inside tiles where glyph pixel is transparent and outside tiles
//  SYNC_ACTIVE    0        active level of hsync/vsync
// PORTS
//  clk           in   1   pixel clock
//  reset         in   1   asynchronous, active-low reset
//  x             in   10  pixel column, aligned with tile flags
//  y             in   9   pixel row, aligned with tile flags
//  active_in     in   1   visible-area flag from VGA timing
//  hsync_in      in   1   horizontal sync from VGA timing
//  vsync_in      in   1   vertical sync from VGA timing
//  square_total  in   1   pixel lies in any tile
//  highlight     in   1   pixel lies in a highlighted (editable clock) tile
//  welcome       in   1   pixel lies in a welcome-banner tile
//  sprite_addr   in   19  sprite ROM address from tile decoder
//  rom_addr      out  19  registered address to sync ROM
//  rom_data      in   8   ROM word, valid 1 cycle after rom_addr; 0 = transparent
//  vga_r/g/b     out  4   registered colour channels
//  hsync         out  1   delayed hsync
//  vsync         out  1   delayed vsync
// BEHAVIOUR
//  - Reset (reset=0, async): rom_addr=0, vga_r/g/b=0, hsync=vsync=~SYNC_ACTIVE, all pipe
//    flags 0, frame_cnt=0, blink_on=1. Normal operation resumes on first clk after release.
//  - Pipeline, 3 stages, fixed latency 3 clk from inputs to RGB/sync:
//    S1: register flags, active_in, syncs; rom_addr<=sprite_addr if in-range and square_total,
//        else 0; oob flag = square_total & (sprite_addr>=ROM_DEPTH).
//    S2: ROM access; S1 flags shifted.
//    S3: colour select, registered into vga_*; hsync/vsync output same cycle.
//  - Colour select (S3 priority): !active -> 12'h000; !square_total -> BG_COLOR;
//    oob or rom_data==0 -> BG_COLOR; highlight & blink_on -> HL_COLOR;
//    highlight & !blink_on -> BG_COLOR; welcome -> WEL_COLOR; else FG_COLOR.
//    highlight outranks welcome if both set.
//  - Blink: frame edge = transition of vsync_in into SYNC_ACTIVE. On edge: if
//    frame_cnt==BLINK_FRAMES-1 then frame_cnt<=0, blink_on<=~blink_on, else frame_cnt++.
//    Counter width $clog2(BLINK_FRAMES)+1; no other wrap. blink_on change takes effect on
//    pixels entering S1 after the edge; no mid-pixel glitches.
//  - vsync held active across reset release: no edge counted until a fresh inactive->active.
//  - Flags, address and rom_data pass unmodified in width; no arithmetic beyond compare.
// CONFIGURATION
//  BLINK_EN defined: blink logic as above.
//  BLINK_EN undefined: frame_cnt/blink_on removed, blink_on treated as constant 1;
//    highlighted glyph pixels always HL_COLOR. Latency and all other behaviour unchanged.
// TESTING
//  1. Reset low mid-frame with active_in=1 -> RGB=0, hsync=vsync=1 immediately (async); after
//     release first valid pixel appears 3 clk after inputs.
//  2. square_total=1, welcome=1, sprite_addr=2550, rom_data=8'h80 -> rom_addr=2550 next clk,
//     RGB=12'h0F0 3 clk after input; rom_data=0 -> RGB=BG_COLOR.
//  3. active_in=0 with square_total=1, rom_data=8'hFF -> RGB=0; hsync_in pulse appears on
//     hsync exactly 3 clk later.
//  4. sprite_addr=19'd300000, square_total=1 -> rom_addr=0, RGB=BG_COLOR regardless of rom_data.
//  5. BLINK_EN, highlight=1, rom_data=1: frames 0-29 RGB=12'hFF0, frames 30-59 BG_COLOR,
//     frame 60 12'hFF0; without BLINK_EN all 60 frames 12'hFF0.
//  6. highlight=1 & welcome=1, blink_on=1 -> HL_COLOR (priority check).

Source files
------------

// File: rtl/sprite_pixel_pipe.sv
// Sprite pixel pipeline: tile flags + sprite address -> sync ROM fetch -> colour select -> VGA RGB/sync.
// Optional blink of highlighted glyphs is enabled by defining BLINK_EN.
module sprite_pixel_pipe #(
    parameter int          ROM_DEPTH    = 300000,
    parameter int          BLINK_FRAMES = 30,
    parameter logic [11:0] FG_COLOR     = 12'hFFF,
    parameter logic [11:0] WEL_COLOR    = 12'h0F0,
    parameter logic [11:0] HL_COLOR     = 12'hFF0,
    parameter logic [11:0] BG_COLOR     = 12'h000,
    parameter logic        SYNC_ACTIVE  = 1'b0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [9:0]  x,
    input  logic [8:0]  y,
    input  logic        active_in,
    input  logic        hsync_in,
    input  logic        vsync_in,
    input  logic        square_total,
    input  logic        highlight,
    input  logic        welcome,
    input  logic [18:0] sprite_addr,
    output logic [18:0] rom_addr,
    input  logic [7:0]  rom_data,
    output logic [3:0]  vga_r,
    output logic [3:0]  vga_g,
    output logic [3:0]  vga_b,
    output logic        hsync,
    output logic        vsync
);

    localparam logic [19:0] DEPTH_W = 20'(ROM_DEPTH);

    typedef struct packed {
        logic active;
        logic sq;
        logic hl;
        logic wel;
        logic oob;
        logic blink;
        logic hs;
        logic vs;
    } stage_t;

    localparam stage_t STAGE_RST = '{active: 1'b0, sq: 1'b0, hl: 1'b0, wel: 1'b0, oob: 1'b0,
                                     blink: 1'b0, hs: ~SYNC_ACTIVE, vs: ~SYNC_ACTIVE};

    function automatic logic [11:0] pick_colour(input stage_t s, input logic [7:0] d);
        logic [11:0] c;
        if (!s.active)                c = 12'h000;
        else if (!s.sq)               c = BG_COLOR;
        else if (s.oob || d == 8'h00) c = BG_COLOR;
        else if (s.hl)                c = s.blink ? HL_COLOR : BG_COLOR;
        else if (s.wel)               c = WEL_COLOR;
        else                          c = FG_COLOR;
        return c;
    endfunction

    // Pixel position travels with the flags upstream but is not needed here.
    logic unused_xy;
    assign unused_xy = ^{x, y};

    logic blink_cur;

`ifdef BLINK_EN
    localparam int CNT_W = $clog2(BLINK_FRAMES) + 1;

    logic             vs_prev_q, vs_prev_d;
    logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;
    logic             blink_on_q, blink_on_d;
    logic             frame_edge;

    always_comb begin
        frame_edge  = (vsync_in == SYNC_ACTIVE) && (vs_prev_q != SYNC_ACTIVE);
        vs_prev_d   = vsync_in;
        frame_cnt_d = frame_cnt_q;
        blink_on_d  = blink_on_q;
        if (frame_edge) begin
            if (frame_cnt_q == CNT_W'(BLINK_FRAMES - 1)) begin
                frame_cnt_d = '0;
                blink_on_d  = ~blink_on_q;
            end else begin
                frame_cnt_d = frame_cnt_q + 1'b1;
            end
        end
    end

    // vs_prev resets to the active level so a vsync held active over release is not an edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vs_prev_q   <= SYNC_ACTIVE;
            frame_cnt_q <= '0;
            blink_on_q  <= 1'b1;
        end else begin
            vs_prev_q   <= vs_prev_d;
            frame_cnt_q <= frame_cnt_d;
            blink_on_q  <= blink_on_d;
        end
    end

    assign blink_cur = blink_on_q;
`else
    assign blink_cur = 1'b1;
`endif

    stage_t      stage_p1_q, stage_p1_d;
    stage_t      stage_p2_q, stage_p2_d;
    logic [18:0] rom_addr_q, rom_addr_d;
    logic [11:0] rgb_q, rgb_d;
    logic        hsync_q, hsync_d;
    logic        vsync_q, vsync_d;
    logic        in_range;

    // S1: capture flags, issue ROM address
    always_comb begin
        in_range   = {1'b0, sprite_addr} < DEPTH_W;
        rom_addr_d = (square_total && in_range) ? sprite_addr : '0;
        stage_p1_d = '{active: active_in, sq: square_total, hl: highlight, wel: welcome,
                       oob: square_total & ~in_range, blink: blink_cur,
                       hs: hsync_in, vs: vsync_in};
    end

    // S2: ROM access in flight, flags follow
    always_comb begin
        stage_p2_d = stage_p1_q;
    end

    // S3: colour select with rom_data now valid
    always_comb begin
        rgb_d   = pick_colour(stage_p2_q, rom_data);
        hsync_d = stage_p2_q.hs;
        vsync_d = stage_p2_q.vs;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stage_p1_q <= STAGE_RST;
            stage_p2_q <= STAGE_RST;
            rom_addr_q <= '0;
            rgb_q      <= '0;
            hsync_q    <= ~SYNC_ACTIVE;
            vsync_q    <= ~SYNC_ACTIVE;
        end else begin
            stage_p1_q <= stage_p1_d;
            stage_p2_q <= stage_p2_d;
            rom_addr_q <= rom_addr_d;
            rgb_q      <= rgb_d;
            hsync_q    <= hsync_d;
            vsync_q    <= vsync_d;
        end
    end

    assign rom_addr = rom_addr_q;
    assign vga_r    = rgb_q[11:8];
    assign vga_g    = rgb_q[7:4];
    assign vga_b    = rgb_q[3:0];
    assign hsync    = hsync_q;
    assign vsync    = vsync_q;

endmodule

// File: tb/tb_sprite_pixel_pipe.sv
// Scoreboard bench for sprite_pixel_pipe: randomized pixels/frames against a frame-counting reference model.
module tb_sprite_pixel_pipe;

    localparam int          ROM_DEPTH = 300000;
    localparam int          BF        = 30;
    localparam logic [11:0] FG  = 12'hFFF;
    localparam logic [11:0] WEL = 12'h0F0;
    localparam logic [11:0] HL  = 12'hFF0;
    localparam logic [11:0] BG  = 12'h000;

    logic        clk = 1'b0;
    logic        reset;
    logic [9:0]  x;
    logic [8:0]  y;
    logic        active_in, hsync_in, vsync_in;
    logic        square_total, highlight, welcome;
    logic [18:0] sprite_addr;
    logic [18:0] rom_addr;
    logic [7:0]  rom_data;
    logic [3:0]  vga_r, vga_g, vga_b;
    logic        hsync, vsync;

    always #5 clk = ~clk;

    sprite_pixel_pipe dut (
        .clk(clk), .reset(reset), .x(x), .y(y),
        .active_in(active_in), .hsync_in(hsync_in), .vsync_in(vsync_in),
        .square_total(square_total), .highlight(highlight), .welcome(welcome),
        .sprite_addr(sprite_addr), .rom_addr(rom_addr), .rom_data(rom_data),
        .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b), .hsync(hsync), .vsync(vsync)
    );

    function automatic logic [7:0] rom_fn(input logic [18:0] a);
        int v;
        v = int'(a);
        if (v % 7 == 3) return 8'h00;
        return 8'((v * 13) % 255 + 1);
    endfunction

    always @(posedge clk) rom_data <= rom_fn(rom_addr);

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { int due; logic [11:0] rgb; logic hs; logic vs; } exp_t;
    typedef struct { int due; logic [18:0] a; } aexp_t;
    exp_t  q[$];
    aexp_t aq[$];

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    // reference model state: number of frame starts seen since reset, last vsync level
    int   edges;
    logic prev_vs;

    task automatic model_reset();
        edges   = 0;
        prev_vs = 1'b0;
        q.delete();
        aq.delete();
    endtask

    task automatic drive(input logic act, input logic hs, input logic vs, input logic sq,
                         input logic hl, input logic wl, input logic [18:0] addr);
        exp_t  e;
        aexp_t ae;
        logic  blink;
        logic  oob;
        @(negedge clk);
        active_in = act; hsync_in = hs; vsync_in = vs;
        square_total = sq; highlight = hl; welcome = wl; sprite_addr = addr;
        x = 10'($urandom_range(0, 639));
        y = 9'($urandom_range(0, 479));
`ifdef BLINK_EN
        blink = ((edges / BF) % 2) == 0;
`else
        blink = 1'b1;
`endif
        oob = int'(addr) >= ROM_DEPTH;
        if (!act)                                e.rgb = 12'h000;
        else if (!sq)                            e.rgb = BG;
        else if (oob || rom_fn(addr) == 8'h00)   e.rgb = BG;
        else if (hl)                             e.rgb = blink ? HL : BG;
        else if (wl)                             e.rgb = WEL;
        else                                     e.rgb = FG;
        e.hs  = hs;
        e.vs  = vs;
        e.due = cyc + 3;
        q.push_back(e);
        ae.due = cyc + 1;
        ae.a   = (sq && !oob) ? addr : 19'd0;
        aq.push_back(ae);
        if (vs == 1'b0 && prev_vs == 1'b1) edges++;
        prev_vs = vs;
    endtask

    task automatic rand_pixel(input logic vs);
        logic [18:0] a;
        case ($urandom_range(0, 7))
            0:       a = 19'd2550;
            1:       a = 19'(ROM_DEPTH - 1 + int'($urandom_range(0, 2)));
            default: a = 19'($urandom_range(0, 5999));
        endcase
        drive($urandom_range(0, 7) != 0, $urandom_range(0, 7) == 0, vs,
              $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
              $urandom_range(0, 1) == 1, a);
    endtask

    task automatic run_frames(input int nframes);
        for (int f = 0; f < nframes; f++) begin
            for (int p = 0; p < 6; p++) begin
                if (p == 0) drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 19'd2550);
                else        rand_pixel(p >= 4 ? 1'b0 : 1'b1);
            end
        end
    endtask

    // monitor: compares whatever the DUT presents against the scoreboard when due
    always @(posedge clk) begin
        #1;
        if (reset) begin
            if (aq.size() > 0 && aq[0].due == cyc) begin
                check("rom_addr", 32'(rom_addr), 32'(aq[0].a));
                void'(aq.pop_front());
            end
            if (q.size() > 0 && q[0].due == cyc) begin
                check("rgb", 32'({vga_r, vga_g, vga_b}), 32'(q[0].rgb));
                check("hsync", 32'(hsync), 32'(q[0].hs));
                check("vsync", 32'(vsync), 32'(q[0].vs));
                void'(q.pop_front());
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_rgb"}, 32'({vga_r, vga_g, vga_b}), 32'h0);
        check({tag, "_hsync"}, 32'(hsync), 32'h1);
        check({tag, "_vsync"}, 32'(vsync), 32'h1);
        check({tag, "_rom_addr"}, 32'(rom_addr), 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0;
        active_in = 1'b1; hsync_in = 1'b1; vsync_in = 1'b0;
        square_total = 1'b1; highlight = 1'b0; welcome = 1'b0;
        sprite_addr = 19'd2550; x = '0; y = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("por");
        @(negedge clk);
        reset = 1'b1;

        // directed cases, vsync held active across release (no frame edge)
        drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 19'd2550);
        drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 19'd3);
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 19'd2550);
        drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 19'd300000);
        drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 19'd2550);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 19'd2550);
        drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 19'd299999);

        // 65 short frames cover two blink half-periods and the return to on
        run_frames(65);

        // asynchronous reset mid-frame with active pixels in flight
        @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        check_reset_outputs("async");
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        run_frames(8);
        repeat (6) @(negedge clk);
        check("drain_rgb_queue", 32'(q.size()), 32'h0);
        check("drain_addr_queue", 32'(aq.size()), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
